// File: rtl/wm8731_i2c_config_if.sv
// Control/status bus of the WM8731 configuration sequencer plus the SCL line.
// The open-drain SDA pin stays a plain inout on the module.
interface wm8731_i2c_config_if;
  logic       reconfig;
  logic       i2c_sclk;
  logic       busy;
  logic       ready;
  logic       error;
  logic [3:0] word_idx;

  // Sequencer side
  modport master (
    input  reconfig,
    output i2c_sclk, busy, ready, error, word_idx
  );

  // Board-logic side
  modport slave (
    output reconfig,
    input  i2c_sclk, busy, ready, error, word_idx
  );
endinterface

// File: rtl/wm8731_i2c_config.sv
// WM8731 codec configuration sequencer with a built-in bit-level I2C master.
// Writes 11 register words to device 0x1A (write byte 0x34) after reset or on reconfig.
// Optional macro WM8731_CONFIG_NACK_RETRY_EN: re-send a NACKed word up to max_retries times.
module wm8731_i2c_config #(
  parameter int unsigned clk_mhz     = 50,
  parameter int unsigned scl_khz     = 100,
  parameter int unsigned startup_us  = 1000,
  parameter int unsigned gap_us      = 10,
  parameter int unsigned max_retries = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  wm8731_i2c_config_if.master        bus,
  inout  wire                        i2c_sdat
);

  localparam int unsigned q_div       = clk_mhz * 1000 / (4 * scl_khz);
  localparam int unsigned div_w       = (q_div > 1) ? $clog2(q_div) : 1;
  localparam int unsigned startup_cyc = startup_us * clk_mhz;
  localparam int unsigned gap_cyc     = gap_us * clk_mhz;
  localparam int unsigned cnt_max     = (startup_cyc > gap_cyc) ? startup_cyc : gap_cyc;
  localparam int unsigned cnt_w       = $clog2(cnt_max + 1);
  localparam logic [7:0]  dev_wr      = 8'h34;
  localparam logic [3:0]  last_word   = 4'd10;

  typedef enum logic [2:0] {
    S_POWERUP, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [div_w-1:0]   div_q, div_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d;
  logic [1:0]         qtr_q, qtr_d;
  logic [2:0]         bit_q, bit_d;
  logic [1:0]         byte_q, byte_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               failed_q, failed_d;
  logic [3:0]         word_idx_q, word_idx_d;
  logic               scl_q, scl_d;
  logic               sda_oe_q, sda_oe_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               error_q, error_d;
  logic               tick_c;
  logic               sda_in_c;
  logic [15:0]        word_c;

`ifdef WM8731_CONFIG_NACK_RETRY_EN
  localparam int unsigned retry_w = (max_retries > 0) ? $clog2(max_retries + 1) : 1;
  logic [retry_w-1:0] retry_q, retry_d;
`else
  // The retry limit only matters when retries are enabled.
  logic unused_retry_c;
  assign unused_retry_c = ^32'(max_retries);
`endif

  // Register table: {reg[6:0], data[8:0]}.
  function automatic logic [15:0] cfg_word(input logic [3:0] idx);
    logic [15:0] w;
    w = 16'h0000;
    case (idx)
      4'd0:    w = 16'h1E00;
      4'd1:    w = 16'h0017;
      4'd2:    w = 16'h0217;
      4'd3:    w = 16'h0479;
      4'd4:    w = 16'h0679;
      4'd5:    w = 16'h0812;
      4'd6:    w = 16'h0A00;
      4'd7:    w = 16'h0C00;
      4'd8:    w = 16'h0E02;
      4'd9:    w = 16'h1000;
      4'd10:   w = 16'h1201;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  assign tick_c       = (div_q == div_w'(q_div - 1));
  assign word_c       = cfg_word(word_idx_q);
  assign sda_in_c     = i2c_sdat;
  assign i2c_sdat     = sda_oe_q ? 1'b0 : 1'bz;
  assign bus.i2c_sclk = scl_q;
  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;
  assign bus.error    = error_q;
  assign bus.word_idx = word_idx_q;

  // Sequencer next state: quarter-period I2C phases plus power-up and gap timers.
  always_comb begin
    div_d      = tick_c ? '0 : div_q + div_w'(1);
    state_d    = state_q;
    cnt_d      = cnt_q;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    shreg_d    = shreg_q;
    failed_d   = failed_q;
    word_idx_d = word_idx_q;
    scl_d      = scl_q;
    sda_oe_d   = sda_oe_q;
`ifdef WM8731_CONFIG_NACK_RETRY_EN
    retry_d    = retry_q;
`endif
    case (state_q)
      S_POWERUP: begin
        if (cnt_q == cnt_w'(startup_cyc - 1)) begin
          cnt_d      = '0;
          word_idx_d = '0;
          qtr_d      = '0;
          failed_d   = 1'b0;
          state_d    = S_START;
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      S_START: begin
        if (tick_c) begin
          if (qtr_q == 2'd0) begin
            sda_oe_d = 1'b1;
            scl_d    = 1'b1;
            qtr_d    = 2'd1;
          end else begin
            scl_d   = 1'b0;
            shreg_d = dev_wr;
            byte_d  = 2'd0;
            bit_d   = 3'd0;
            qtr_d   = 2'd0;
            state_d = S_BIT;
          end
        end
      end
      S_BIT: begin
        if (tick_c) begin
          qtr_d = qtr_q + 2'd1;
          case (qtr_q)
            2'd0: begin
              scl_d    = 1'b0;
              sda_oe_d = ~shreg_q[7];
            end
            2'd1, 2'd2: scl_d = 1'b1;
            default: begin
              scl_d   = 1'b0;
              shreg_d = {shreg_q[6:0], 1'b0};
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = S_ACK;
            end
          endcase
        end
      end
      S_ACK: begin
        if (tick_c) begin
          qtr_d = qtr_q + 2'd1;
          case (qtr_q)
            2'd0: begin
              scl_d    = 1'b0;
              sda_oe_d = 1'b0;
            end
            2'd1, 2'd2: scl_d = 1'b1;
            default: begin
              // SDA sampled as SCL falls, i.e. at the end of the second high quarter.
              scl_d = 1'b0;
              if (sda_in_c) begin
                failed_d = 1'b1;
                state_d  = S_STOP;
              end else if (byte_q == 2'd2) begin
                state_d = S_STOP;
              end else begin
                byte_d  = byte_q + 2'd1;
                shreg_d = (byte_q == 2'd0) ? word_c[15:8] : word_c[7:0];
                state_d = S_BIT;
              end
            end
          endcase
        end
      end
      S_STOP: begin
        if (tick_c) begin
          case (qtr_q)
            2'd0: begin
              sda_oe_d = 1'b1;
              scl_d    = 1'b0;
              qtr_d    = 2'd1;
            end
            2'd1: begin
              scl_d = 1'b1;
              qtr_d = 2'd2;
            end
            default: begin
              sda_oe_d = 1'b0;
              qtr_d    = 2'd0;
              cnt_d    = '0;
              state_d  = S_GAP;
            end
          endcase
        end
      end
      S_GAP: begin
        if (cnt_q == cnt_w'(gap_cyc - 1)) begin
          cnt_d    = '0;
          qtr_d    = '0;
          failed_d = 1'b0;
          if (failed_q) begin
`ifdef WM8731_CONFIG_NACK_RETRY_EN
            if (retry_q < retry_w'(max_retries)) begin
              retry_d = retry_q + retry_w'(1);
              state_d = S_START;
            end else begin
              state_d = S_ERROR;
            end
`else
            state_d = S_ERROR;
`endif
          end else if (word_idx_q == last_word) begin
            state_d = S_DONE;
          end else begin
            word_idx_d = word_idx_q + 4'd1;
`ifdef WM8731_CONFIG_NACK_RETRY_EN
            retry_d    = '0;
`endif
            state_d    = S_START;
          end
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      default: begin
        // DONE / ERROR: lines idle, wait for a reconfig request.
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        if (bus.reconfig) begin
          word_idx_d = '0;
          qtr_d      = '0;
          failed_d   = 1'b0;
`ifdef WM8731_CONFIG_NACK_RETRY_EN
          retry_d    = '0;
`endif
          state_d    = S_START;
        end
      end
    endcase
    busy_d  = !((state_d == S_DONE) || (state_d == S_ERROR));
    ready_d = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  // All sequencer state and outputs; reset releases both lines at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_POWERUP;
      div_q      <= '0;
      cnt_q      <= '0;
      qtr_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      shreg_q    <= '0;
      failed_q   <= 1'b0;
      word_idx_q <= '0;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
`ifdef WM8731_CONFIG_NACK_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shreg_q    <= shreg_d;
      failed_q   <= failed_d;
      word_idx_q <= word_idx_d;
      scl_q      <= scl_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
`ifdef WM8731_CONFIG_NACK_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_wm8731_i2c_config.sv
// Bench for wm8731_i2c_config: I2C slave/monitor, table-driven and random NACK scenarios,
// reconfig and mid-transaction reset sequences.
`timescale 1ns/1ps
module tb_wm8731_i2c_config;

  localparam int qd          = 4;    // 50 MHz / (4 * 3125 kHz)
  localparam int startup_cyc = 50;
  localparam int max_retries = 3;
`ifdef WM8731_CONFIG_NACK_RETRY_EN
  localparam bit retry_en = 1'b1;
`else
  localparam bit retry_en = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slave_low = 1'b0;
  wire  sda_w;

  wm8731_i2c_config_if bus ();

  assign sda_w = slave_low ? 1'b0 : 1'bz;
  pullup (sda_w);

  wm8731_i2c_config #(
    .clk_mhz(50), .scl_khz(3125), .startup_us(1), .gap_us(1), .max_retries(max_retries)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .i2c_sdat(sda_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit via_reset;
    bit poke;
    int nack_word;   // -1: never NACK
    int nack_byte;   // 0 address, 1 byte1, 2 byte2
    int nack_count;  // attempts of that word that get NACKed
    bit exp_ok_b;  int exp_idx_b;   // without retries
    bit exp_ok_r;  int exp_idx_r;   // with retries
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Monitor / slave state
  int       cyc = 0;
  int       start_cnt, stop_cnt, proto_err, timing_err, first_start_cyc;
  int       acked_words, bitcnt, bytepos, last_edge;
  int       nack_word, nack_byte, nack_left;
  bit       in_trans, hi_bit, nacked_this, prev_scl, prev_sda;
  logic [7:0] cur;
  logic [7:0] rx_q[$];

  // Reference model results
  logic [7:0] exp_q[$];
  int       m_attempts, m_idx;
  bit       m_ok;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] cfg_word(input int i);
    logic [15:0] t [11];
    t = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
          16'h0A00, 16'h0C00, 16'h0E02, 16'h1000, 16'h1201};
    return t[i];
  endfunction

  function automatic logic [7:0] byte_of(input int w, input int b);
    logic [15:0] x;
    x = cfg_word(w);
    if (b == 0) return 8'h34;
    return (b == 1) ? x[15:8] : x[7:0];
  endfunction

  // Expected byte stream and outcome straight from the word table and NACK rules.
  task automatic build_expect(input vec_t v);
    int tries;
    bit nk;
    exp_q.delete();
    m_attempts = 0; m_ok = 1'b1; m_idx = 10;
    for (int w = 0; w < 11; w++) begin
      tries = 0;
      forever begin
        nk = (w == v.nack_word) && (tries < v.nack_count);
        for (int b = 0; b < 3; b++)
          if (!nk || b <= v.nack_byte) exp_q.push_back(byte_of(w, b));
        m_attempts++; tries++;
        if (!nk) break;
        if (!retry_en || tries > max_retries) begin
          m_ok = 1'b0; m_idx = w;
          return;
        end
      end
    end
  endtask

  // Bus monitor and ACKing slave, sampled on the falling clock edge.
  initial begin
    bit scl, sda, nk;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_trans = 0; hi_bit = 0; bitcnt = 0; bytepos = 0; slave_low = 1'b0;
        prev_scl = 1; prev_sda = 1;
      end else begin
        scl = bus.i2c_sclk;
        sda = (sda_w !== 1'b0);
        if (scl && prev_scl && sda != prev_sda) begin
          hi_bit = 0;
          if (!sda) begin
            if (in_trans) proto_err++;
            in_trans = 1; bitcnt = 0; bytepos = 0; nacked_this = 0;
            start_cnt++;
            if (first_start_cyc < 0) first_start_cyc = cyc;
          end else begin
            if (!in_trans || bitcnt != 1) proto_err++;
            in_trans = 0;
            stop_cnt++;
            if (!nacked_this) acked_words++;
          end
        end else if (scl && !prev_scl) begin
          if (in_trans) begin
            if (cyc - last_edge != 2 * qd) timing_err++;
            if (bitcnt < 8) cur = {cur[6:0], sda};
            bitcnt++;
            hi_bit = 1;
          end
          last_edge = cyc;
        end else if (!scl && prev_scl) begin
          if (hi_bit && (cyc - last_edge != 2 * qd)) timing_err++;
          hi_bit = 0;
          if (in_trans) begin
            if (bitcnt == 8) begin
              rx_q.push_back(cur);
              nk = (acked_words == nack_word) && (nack_left > 0) && (bytepos == nack_byte);
              if (nk) begin
                nack_left--; nacked_this = 1; slave_low = 1'b0;
              end else begin
                slave_low = 1'b1;
              end
            end else if (bitcnt == 9) begin
              slave_low = 1'b0; bitcnt = 0; bytepos++;
            end
          end
          last_edge = cyc;
        end
        prev_scl = scl;
        prev_sda = sda;
      end
    end
  end

  task automatic clear_mon(input vec_t v);
    nack_word = v.nack_word; nack_byte = v.nack_byte; nack_left = v.nack_count;
    acked_words = 0; start_cnt = 0; stop_cnt = 0; proto_err = 0; timing_err = 0;
    first_start_cyc = -1;
    rx_q.delete();
  endtask

  task automatic pulse_reconfig();
    @(posedge clk); #1 bus.reconfig = 1'b1;
    @(posedge clk); #1 bus.reconfig = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n, t0, mism;
    bit exp_ok;
    int exp_idx;
    build_expect(v);
    exp_ok  = retry_en ? v.exp_ok_r  : v.exp_ok_b;
    exp_idx = retry_en ? v.exp_idx_r : v.exp_idx_b;
    if (v.via_reset) begin
      @(posedge clk); #1 rst = 1'b1;
      #2;
      chk({nm, "_rst_scl"},   int'(bus.i2c_sclk), 1);
      chk({nm, "_rst_sda"},   int'(sda_w !== 1'b0), 1);
      chk({nm, "_rst_busy"},  int'(bus.busy), 0);
      chk({nm, "_rst_ready"}, int'(bus.ready), 0);
      chk({nm, "_rst_error"}, int'(bus.error), 0);
      chk({nm, "_rst_idx"},   int'(bus.word_idx), 0);
      repeat (2) @(posedge clk);
      clear_mon(v);
      #1 rst = 1'b0;
      @(negedge clk); #1 t0 = cyc;
    end else begin
      clear_mon(v);
      pulse_reconfig();
      chk({nm, "_busy_after_reconfig"},  int'(bus.busy), 1);
      chk({nm, "_ready_after_reconfig"}, int'(bus.ready), 0);
      t0 = cyc;
    end
    if (v.poke) begin
      repeat (100) @(posedge clk);
      if (bus.busy) pulse_reconfig();
    end
    n = 0;
    while (!(bus.ready || bus.error) && n < 12000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_finished_in_budget"}, int'(n < 12000), 1);
    repeat (300) @(negedge clk);
    #1;
    chk({nm, "_ready"}, int'(bus.ready), int'(exp_ok));
    chk({nm, "_error"}, int'(bus.error), int'(!exp_ok));
    chk({nm, "_busy"},  int'(bus.busy), 0);
    chk({nm, "_idx"},   int'(bus.word_idx), exp_idx);
    chk({nm, "_starts"}, start_cnt, m_attempts);
    chk({nm, "_stops"},  stop_cnt,  m_attempts);
    chk({nm, "_rx_len"}, rx_q.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) mism++;
    chk({nm, "_rx_byte_mismatches"}, mism, 0);
    chk({nm, "_protocol_errs"}, proto_err, 0);
    chk({nm, "_scl_timing_errs"}, timing_err, 0);
    if (v.via_reset)
      chk({nm, "_powerup_delay"}, int'(first_start_cyc - t0 >= startup_cyc - 1), 1);
    else
      chk({nm, "_no_powerup_delay"},
          int'(first_start_cyc >= 0 && first_start_cyc - t0 <= 2 * qd), 1);
  endtask

  initial begin
    vec_t tbl [7];
    vec_t v;
    int   n;
    bus.reconfig = 1'b0;
    clear_mon('{0, 0, -1, 0, 0, 1, 10, 1, 10});
    //          rst poke word byte cnt okb idxb okr idxr
    tbl[0] = '{1, 0, -1, 0, 0, 1, 10, 1, 10};
    tbl[1] = '{0, 0,  3, 0, 1, 0,  3, 1, 10};
    tbl[2] = '{0, 0,  5, 1, 2, 0,  5, 1, 10};
    tbl[3] = '{0, 0,  5, 2, 9, 0,  5, 0,  5};
    tbl[4] = '{0, 1,  0, 0, 1, 0,  0, 1, 10};
    tbl[5] = '{0, 0, 10, 2, 1, 0, 10, 1, 10};
    tbl[6] = '{0, 1, -1, 0, 0, 1, 10, 1, 10};
    for (int k = 0; k < 7; k++) run_vec(tbl[k], $sformatf("tbl%0d", k));

    // Random NACK placements, expectations from the model.
    for (int k = 0; k < 3; k++) begin
      v.via_reset  = 0;
      v.poke       = bit'($urandom_range(0, 1));
      v.nack_word  = int'($urandom_range(0, 12));
      if (v.nack_word > 10) v.nack_word = -1;
      v.nack_byte  = int'($urandom_range(0, 2));
      v.nack_count = int'($urandom_range(0, 5));
      build_expect(v);
      v.exp_ok_b = m_ok; v.exp_idx_b = m_idx;
      v.exp_ok_r = m_ok; v.exp_idx_r = m_idx;
      run_vec(v, $sformatf("rnd%0d", k));
    end

    // Reset during byte2 of word 6: lines released at once, then full restart.
    v = '{0, 0, -1, 0, 0, 1, 10, 1, 10};
    clear_mon(v);
    pulse_reconfig();
    n = 0;
    while (!(acked_words == 6 && bytepos == 2 && bitcnt == 3) && n < 12000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach_word6_byte2", int'(n < 12000), 1);
    chk("mid_idx_before_rst", int'(bus.word_idx), 6);
    @(posedge clk); #1 rst = 1'b1;
    #2;
    chk("mid_rst_scl",  int'(bus.i2c_sclk), 1);
    chk("mid_rst_sda",  int'(sda_w !== 1'b0), 1);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_idx",  int'(bus.word_idx), 0);
    v.via_reset = 1;
    run_vec(v, "restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
